fetch_decode: RTL and testbench
===============================

Name: fetch_decode

Overview:
Program counter, instruction register and instruction decoder for the 16-bit multicycle CPU, sitting directly upstream of the control FSM. It supplies the fetch address to instruction memory, captures the fetched word, and classifies it for the FSM (inst_type, inst_update_flags, inst_update_regfile). It also supplies operand fields to the datapath. The next PC (sequential, branch, jump or JAL) is resolved here when the FSM asserts ctrl_pc_en.

Parameters:
ADDR_W, 16, PC / instruction-address width (1..16)
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
ctrl_pc_en  in  1  advance PC at this clock edge
ctrl_ir_en  in  1  capture mem_rdata into IR at this clock edge
mem_rdata  in  16  synchronous-read memory data; valid the cycle after pc is presented
reg_target  in  16  Rsrc read data (jump target)
flags  in  5  {C,L,F,Z,N} from the flag register, bit4..bit0
pc  out  ADDR_W  current PC / fetch address
pc_plus1  out  16  zero-extended pc+1 (JAL link value)
ir  out  16  instruction register
inst_type  out  2  0 ALU/branch/jump, 1 load, 2 store, 3 illegal/wait
inst_update_flags  out  1  instruction writes flags
inst_update_regfile  out  1  instruction writes Rdest
link_sel  out  1  writeback selects pc_plus1 (JAL)
use_imm  out  1  ALU B operand is imm
imm  out  16  extended immediate
rdest  out  4  decoded ir[11:8]
rsrc  out  4  decoded ir[3:0]

Behaviour:
- Reset: pc=RESET_PC, ir=16'h0000. All decode outputs follow from the decode word.
- Decode word: dw = ctrl_ir_en ? mem_rdata : ir. All decode outputs are combinational from dw, so the FSM's DECODE-state branch sees the new instruction in the same cycle it is captured. op=dw[15:12], ext=dw[7:4].
- IR: loads mem_rdata on an edge with ctrl_ir_en=1; otherwise holds.
- Register ALU (op 0000): ext in {0001 AND, 0010 OR, 0011 XOR, 0101 ADD, 0110 ADDU, 0111 ADDC, 1001 SUB, 1010 SUBC, 1011 CMP, 1101 MOV} gives type 0, use_imm=0.
  - regfile=1 for all except CMP.
  - flags=1 for ADD, ADDU, ADDC, SUB, SUBC, CMP.
- Immediate ALU: op equal to one of the ext codes above uses the same flag/regfile rules, use_imm=1.
  - imm = zero-extend dw[7:0] for AND/OR/XOR; sign-extend otherwise.
- Shift (op 1000): type 0, regfile=1, flags=0.
  - ext 0100: LSH, use_imm=0.
  - ext 000x: LSHI, use_imm=1, imm=sext(dw[3:0]).
- LUI (op 1111): type 0, regfile=1, use_imm=1, imm={dw[7:0],8'h00}.
- Load/store/jump (op 0100):
  - ext 0000 LOAD: type 1, regfile=1.
  - ext 0100 STOR: type 2.
  - ext 1000 JAL: type 0, regfile=1, link_sel=1.
  - ext 1100 Jcond: type 0, no writes.
- Bcond (op 1100): type 0, no writes.
- Any other encoding: type 3, all write flags 0. PC is never advanced for type 3, so the CPU holds (wait/halt).
- Condition (cond=ir[11:8]):
  - EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C.
  - HI 0100 L; LS 0101 !L; GT 0110 N; LE 0111 !N.
  - FS 1000 F; FC 1001 !F; LO 1010 !L&!Z; HS 1011 L|Z.
  - LT 1100 !N&!Z; GE 1101 N|Z; UC 1110 1; 1111 0.
- Next PC on an edge with ctrl_pc_en=1, using ir (not dw):
  - Bcond taken: pc + sext({ir[7:4],ir[3:0]}), relative to the branch's own address.
  - Jcond taken, or JAL: reg_target[ADDR_W-1:0].
  - Otherwise: pc+1.
- All PC arithmetic wraps modulo 2^ADDR_W.
- ctrl_pc_en and ctrl_ir_en on the same edge update independently: next PC uses the old ir, and IR takes mem_rdata.
- Reset mid-instruction returns PC and IR to their reset values immediately.

Test Plan:
- Reset with RESET_PC=0: pc=0, ir=0 -> inst_type=3 (op 0000, ext 0000 illegal). Pulse ctrl_pc_en with ir=ADD -> pc=1.
- mem_rdata=16'h0153 (ADD r1,r3) with ctrl_ir_en=1 -> same cycle inst_type=0, flags=1, regfile=1, use_imm=0, rdest=1, rsrc=3. After the edge, ir=16'h0153.
- ir=16'h5AFF (ADDI r10,-1) -> imm=16'hFFFF, use_imm=1. ir=16'h11FF (ANDI) -> imm=16'h00FF. ir=16'hF312 (LUI) -> imm=16'h1200.
- ir=16'hC0FE (BEQ -2), pc=10: with flags Z=1 and ctrl_pc_en -> pc=8; with Z=0 -> pc=11. At pc=0, BUC +(-1) -> pc=2^ADDR_W-1.
- ir=16'h4283 (JAL r2,r3), reg_target=16'h0040, pc=5 -> link_sel=1, pc_plus1=6, regfile=1; after ctrl_pc_en edge pc=16'h0040.
- ir=16'h4102 (LOAD) -> type 1; ir=16'h4142 (STOR) -> type 2. Assert rst between the ctrl_ir_en and ctrl_pc_en edges -> pc=RESET_PC, ir=0 asynchronously.

Source files
------------

// File: rtl/fetch_decode.sv
`default_nettype none
// ============================================================================
// Module      : fetch_decode
// Description : Program counter, instruction register and instruction decoder
//               for the 16-bit multicycle CPU. Presents the fetch address,
//               captures the fetched word, classifies it for the control FSM
//               and resolves the next PC (sequential / branch / jump / JAL).
// Ports       : clk, rst (async, active-high)
//               ctrl_pc_en, ctrl_ir_en  - FSM strobes for PC advance / IR load
//               mem_rdata               - instruction memory read data
//               reg_target              - Rsrc read data (jump target)
//               flags                   - {C,L,F,Z,N}
//               pc, pc_plus1, ir        - fetch state
//               inst_type, inst_update_flags, inst_update_regfile,
//               link_sel, use_imm, imm, rdest, rsrc - decode outputs
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_decode #(
    parameter int                 ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ctrl_pc_en,
    input  logic              ctrl_ir_en,
    input  logic [15:0]       mem_rdata,
    input  logic [15:0]       reg_target,
    input  logic [4:0]        flags,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       pc_plus1,
    output logic [15:0]       ir,
    output logic [1:0]        inst_type,
    output logic              inst_update_flags,
    output logic              inst_update_regfile,
    output logic              link_sel,
    output logic              use_imm,
    output logic [15:0]       imm,
    output logic [3:0]        rdest,
    output logic [3:0]        rsrc
);

    localparam logic [1:0] c_TYPE_ALU  = 2'd0;
    localparam logic [1:0] c_TYPE_LOAD = 2'd1;
    localparam logic [1:0] c_TYPE_STOR = 2'd2;
    localparam logic [1:0] c_TYPE_ILL  = 2'd3;

    // ALU operation codes shared by the register form (in ext) and the
    // immediate form (in op).
    function automatic logic f_is_alu(input logic [3:0] code);
        case (code)
            4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0110,
            4'b0111, 4'b1001, 4'b1010, 4'b1011, 4'b1101: f_is_alu = 1'b1;
            default:                                       f_is_alu = 1'b0;
        endcase
    endfunction

    // Arithmetic ops (ADD/ADDU/ADDC/SUB/SUBC/CMP) update flags.
    function automatic logic f_alu_flags(input logic [3:0] code);
        case (code)
            4'b0101, 4'b0110, 4'b0111,
            4'b1001, 4'b1010, 4'b1011: f_alu_flags = 1'b1;
            default:                   f_alu_flags = 1'b0;
        endcase
    endfunction

    logic [ADDR_W-1:0] r_pc;
    logic [15:0]       r_ir;

    logic [15:0]       w_dw;
    logic [3:0]        w_op;
    logic [3:0]        w_ext;

    logic              w_c, w_l, w_f, w_z, w_n;
    logic              w_cond_true;
    logic              w_is_bcond;
    logic              w_is_jal;
    logic              w_is_jcond;
    logic [15:0]       w_br_off;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_pc_br;
    logic [ADDR_W-1:0] w_pc_next;

    // ------------------------------------------------------------------
    // PC and IR registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
            r_ir <= 16'h0000;
        end else begin
            if (ctrl_pc_en) begin
                r_pc <= w_pc_next;
            end
            if (ctrl_ir_en) begin
                r_ir <= mem_rdata;
            end
        end
    end

    assign pc       = r_pc;
    assign ir       = r_ir;
    assign w_pc_inc = r_pc + ADDR_W'(1);
    assign pc_plus1 = 16'(w_pc_inc);

    // ------------------------------------------------------------------
    // Next-PC resolution (always from the held IR, never the bypass word)
    // ------------------------------------------------------------------
    assign {w_c, w_l, w_f, w_z, w_n} = flags;

    always_comb begin
        case (r_ir[11:8])
            4'b0000: w_cond_true = w_z;
            4'b0001: w_cond_true = ~w_z;
            4'b0010: w_cond_true = w_c;
            4'b0011: w_cond_true = ~w_c;
            4'b0100: w_cond_true = w_l;
            4'b0101: w_cond_true = ~w_l;
            4'b0110: w_cond_true = w_n;
            4'b0111: w_cond_true = ~w_n;
            4'b1000: w_cond_true = w_f;
            4'b1001: w_cond_true = ~w_f;
            4'b1010: w_cond_true = ~w_l & ~w_z;
            4'b1011: w_cond_true = w_l | w_z;
            4'b1100: w_cond_true = ~w_n & ~w_z;
            4'b1101: w_cond_true = w_n | w_z;
            4'b1110: w_cond_true = 1'b1;
            default: w_cond_true = 1'b0;
        endcase
    end

    assign w_is_bcond = (r_ir[15:12] == 4'b1100);
    assign w_is_jal   = (r_ir[15:12] == 4'b0100) && (r_ir[7:4] == 4'b1000);
    assign w_is_jcond = (r_ir[15:12] == 4'b0100) && (r_ir[7:4] == 4'b1100);

    // Branch displacement is relative to the branch's own address; the
    // truncation to ADDR_W makes the add wrap modulo 2^ADDR_W.
    assign w_br_off = {{8{r_ir[7]}}, r_ir[7:0]};
    assign w_pc_br  = r_pc + w_br_off[ADDR_W-1:0];

    always_comb begin
        w_pc_next = w_pc_inc;
        if (w_is_bcond && w_cond_true) begin
            w_pc_next = w_pc_br;
        end else if (w_is_jal || (w_is_jcond && w_cond_true)) begin
            w_pc_next = reg_target[ADDR_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Decoder. The decode word bypasses the IR while it is being loaded so
    // the FSM sees the new instruction in the same cycle it is captured.
    // ------------------------------------------------------------------
    assign w_dw  = ctrl_ir_en ? mem_rdata : r_ir;
    assign w_op  = w_dw[15:12];
    assign w_ext = w_dw[7:4];
    assign rdest = w_dw[11:8];
    assign rsrc  = w_dw[3:0];

    always_comb begin
        inst_type           = c_TYPE_ILL;
        inst_update_flags   = 1'b0;
        inst_update_regfile = 1'b0;
        link_sel            = 1'b0;
        use_imm             = 1'b0;
        imm                 = {{8{w_dw[7]}}, w_dw[7:0]};
        case (w_op)
            4'b0000: begin
                if (f_is_alu(w_ext)) begin
                    inst_type           = c_TYPE_ALU;
                    inst_update_flags   = f_alu_flags(w_ext);
                    inst_update_regfile = (w_ext != 4'b1011);
                end
            end
            4'b0100: begin
                case (w_ext)
                    4'b0000: begin
                        inst_type           = c_TYPE_LOAD;
                        inst_update_regfile = 1'b1;
                    end
                    4'b0100: inst_type = c_TYPE_STOR;
                    4'b1000: begin
                        inst_type           = c_TYPE_ALU;
                        inst_update_regfile = 1'b1;
                        link_sel            = 1'b1;
                    end
                    4'b1100: inst_type = c_TYPE_ALU;
                    default: inst_type = c_TYPE_ILL;
                endcase
            end
            4'b1000: begin
                if (w_ext == 4'b0100) begin
                    inst_type           = c_TYPE_ALU;
                    inst_update_regfile = 1'b1;
                end else if (w_ext[3:1] == 3'b000) begin
                    inst_type           = c_TYPE_ALU;
                    inst_update_regfile = 1'b1;
                    use_imm             = 1'b1;
                    imm                 = {{12{w_dw[3]}}, w_dw[3:0]};
                end
            end
            4'b1100: inst_type = c_TYPE_ALU;
            4'b1111: begin
                inst_type           = c_TYPE_ALU;
                inst_update_regfile = 1'b1;
                use_imm             = 1'b1;
                imm                 = {w_dw[7:0], 8'h00};
            end
            default: begin
                // Immediate ALU forms; logical ops take a zero-extended imm.
                if (f_is_alu(w_op)) begin
                    inst_type           = c_TYPE_ALU;
                    inst_update_flags   = f_alu_flags(w_op);
                    inst_update_regfile = (w_op != 4'b1011);
                    use_imm             = 1'b1;
                    if (w_op == 4'b0001 || w_op == 4'b0010 || w_op == 4'b0011) begin
                        imm = {8'h00, w_dw[7:0]};
                    end
                end
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_decode
// Description : Scoreboard testbench for fetch_decode. A driver applies
//               directed and random stimulus and pushes expected responses
//               from a behavioural model; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_decode;

    localparam int          ADDR_W   = 16;
    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam int          MASK     = (1 << ADDR_W) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pe  = 1'b0;
    logic        ie  = 1'b0;
    logic [15:0] rd  = 16'h0;
    logic [15:0] tg  = 16'h0;
    logic [4:0]  fl  = 5'h0;

    logic [ADDR_W-1:0] d_pc;
    logic [15:0] d_pc1, d_ir, d_imm;
    logic [1:0]  d_type;
    logic        d_uf, d_ur, d_link, d_ui;
    logic [3:0]  d_rdest, d_rsrc;

    fetch_decode #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC[ADDR_W-1:0])) dut (
        .clk                 (clk),
        .rst                 (rst),
        .ctrl_pc_en          (pe),
        .ctrl_ir_en          (ie),
        .mem_rdata           (rd),
        .reg_target          (tg),
        .flags               (fl),
        .pc                  (d_pc),
        .pc_plus1            (d_pc1),
        .ir                  (d_ir),
        .inst_type           (d_type),
        .inst_update_flags   (d_uf),
        .inst_update_regfile (d_ur),
        .link_sel            (d_link),
        .use_imm             (d_ui),
        .imm                 (d_imm),
        .rdest               (d_rdest),
        .rsrc                (d_rsrc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] pc1;
        logic [15:0] ir;
        logic [1:0]  itype;
        logic        uf;
        logic        ur;
        logic        link;
        logic        ui;
        logic        imm_chk;
        logic [15:0] imm;
        logic [3:0]  rdest;
        logic [3:0]  rsrc;
    } exp_t;

    exp_t scb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // ---------------- behavioural reference model ----------------
    int          m_pc;
    logic [15:0] m_ir;

    function automatic bit alu_code(input int c);
        return c inside {1, 2, 3, 5, 6, 7, 9, 10, 11, 13};
    endfunction

    function automatic bit arith_code(input int c);
        return c inside {5, 6, 7, 9, 10, 11};
    endfunction

    function automatic exp_t ref_decode(input logic [15:0] w);
        exp_t e;
        int   op;
        int   ext;
        e       = '0;
        e.itype = 2'd3;
        op      = int'(w[15:12]);
        ext     = int'(w[7:4]);
        e.rdest = w[11:8];
        e.rsrc  = w[3:0];
        if (op == 0) begin
            if (alu_code(ext)) begin
                e.itype = 0; e.uf = arith_code(ext); e.ur = (ext != 11);
            end
        end else if (alu_code(op)) begin
            e.itype = 0; e.uf = arith_code(op); e.ur = (op != 11);
            e.ui = 1; e.imm_chk = 1;
            e.imm = (op <= 3) ? {8'h00, w[7:0]} : {{8{w[7]}}, w[7:0]};
        end else if (op == 8) begin
            if (ext == 4) begin
                e.itype = 0; e.ur = 1;
            end else if (ext == 0 || ext == 1) begin
                e.itype = 0; e.ur = 1; e.ui = 1; e.imm_chk = 1;
                e.imm = {{12{w[3]}}, w[3:0]};
            end
        end else if (op == 15) begin
            e.itype = 0; e.ur = 1; e.ui = 1; e.imm_chk = 1;
            e.imm = {w[7:0], 8'h00};
        end else if (op == 12) begin
            e.itype = 0;
        end else if (op == 4) begin
            if (ext == 0)       begin e.itype = 1; e.ur = 1; end
            else if (ext == 4)  begin e.itype = 2; end
            else if (ext == 8)  begin e.itype = 0; e.ur = 1; e.link = 1; end
            else if (ext == 12) begin e.itype = 0; end
        end
        return e;
    endfunction

    function automatic bit cond_holds(input logic [3:0] cond, input logic [4:0] f);
        bit c, l, fz, z, n;
        c = f[4]; l = f[3]; fz = f[2]; z = f[1]; n = f[0];
        case (cond)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return l;
            4'd5:  return !l;
            4'd6:  return n;
            4'd7:  return !n;
            4'd8:  return fz;
            4'd9:  return !fz;
            4'd10: return !l && !z;
            4'd11: return l || z;
            4'd12: return !n && !z;
            4'd13: return n || z;
            4'd14: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int ref_next_pc(input int p, input logic [15:0] w,
                                       input logic [15:0] t, input logic [4:0] f);
        int disp;
        disp = int'($signed(w[7:0]));
        if (w[15:12] == 4'd12 && cond_holds(w[11:8], f))
            return (p + disp) & MASK;
        if (w[15:12] == 4'd4 && (w[7:4] == 4'd8 ||
            (w[7:4] == 4'd12 && cond_holds(w[11:8], f))))
            return int'(t) & MASK;
        return (p + 1) & MASK;
    endfunction

    function automatic exp_t expect_now(input logic [15:0] dw);
        exp_t e;
        e     = ref_decode(dw);
        e.pc  = 16'(m_pc);
        e.pc1 = 16'((m_pc + 1) & MASK);
        e.ir  = m_ir;
        return e;
    endfunction

    // ---------------- driver ----------------
    task automatic cyc(input logic p, input logic i, input logic [15:0] r,
                       input logic [15:0] t, input logic [4:0] f);
        @(negedge clk);
        pe = p; ie = i; rd = r; tg = t; fl = f;
        #1;
        scb.push_back(expect_now(i ? r : m_ir));
        if (p) m_pc = ref_next_pc(m_pc, m_ir, t, f);
        if (i) m_ir = r;
    endtask

    task automatic do_reset();
        @(negedge clk);
        pe = 1'b0; ie = 1'b0;
        #1;
        rst  = 1'b1;
        m_pc = int'(RESET_PC);
        m_ir = 16'h0000;
        scb.push_back(expect_now(m_ir));
        #3;
        rst = 1'b0;
    endtask

    // ---------------- monitor ----------------
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (scb.size() > 0) begin
                e = scb.pop_front();
                vectors++;
                chk("pc",       16'(d_pc),        e.pc);
                chk("pc_plus1", d_pc1,            e.pc1);
                chk("ir",       d_ir,             e.ir);
                chk("type",     16'(d_type),      16'(e.itype));
                chk("uflags",   16'(d_uf),        16'(e.uf));
                chk("uregf",    16'(d_ur),        16'(e.ur));
                chk("link",     16'(d_link),      16'(e.link));
                chk("use_imm",  16'(d_ui),        16'(e.ui));
                chk("rdest",    16'(d_rdest),     16'(e.rdest));
                chk("rsrc",     16'(d_rsrc),      16'(e.rsrc));
                if (e.imm_chk) chk("imm", d_imm, e.imm);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        m_pc = int'(RESET_PC);
        m_ir = 16'h0000;

        do_reset();
        cyc(0, 0, 16'h0000, 16'h0, 5'h00);          // idle after reset: illegal
        cyc(0, 1, 16'h0153, 16'h0, 5'h00);          // ADD r1,r3 bypass decode
        cyc(1, 0, 16'h0000, 16'h0, 5'h00);          // pc -> 1
        cyc(0, 1, 16'h5AFF, 16'h0, 5'h00);          // ADDI -1
        cyc(0, 1, 16'h11FF, 16'h0, 5'h00);          // ANDI zero-extend
        cyc(0, 1, 16'hF312, 16'h0, 5'h00);          // LUI
        cyc(0, 0, 16'h0000, 16'h0, 5'h00);

        // BEQ -2 at pc=10, taken and not taken
        cyc(0, 1, 16'h4283, 16'h0, 5'h00);
        cyc(1, 0, 16'h0000, 16'd10, 5'h00);
        cyc(0, 1, 16'hC0FE, 16'h0, 5'h00);
        cyc(1, 0, 16'h0000, 16'h0, 5'b00010);       // Z=1 -> 8
        cyc(0, 1, 16'h4283, 16'h0, 5'h00);
        cyc(1, 0, 16'h0000, 16'd10, 5'h00);
        cyc(0, 1, 16'hC0FE, 16'h0, 5'h00);
        cyc(1, 0, 16'h0000, 16'h0, 5'b00000);       // Z=0 -> 11
        cyc(0, 0, 16'h0000, 16'h0, 5'h00);

        // BUC -1 at pc=0 wraps
        do_reset();
        cyc(0, 1, 16'hCEFF, 16'h0, 5'h00);
        cyc(1, 0, 16'h0000, 16'h0, 5'h00);
        cyc(0, 0, 16'h0000, 16'h0, 5'h00);

        // JAL at pc=5
        cyc(0, 1, 16'h4283, 16'h0, 5'h00);
        cyc(1, 0, 16'h0000, 16'd5, 5'h00);
        cyc(1, 0, 16'h0000, 16'h0040, 5'h00);
        cyc(0, 0, 16'h0000, 16'h0, 5'h00);

        // LOAD, reset between IR and PC strobes, STOR
        cyc(0, 1, 16'h4102, 16'h0, 5'h00);
        do_reset();
        cyc(0, 1, 16'h4142, 16'h0, 5'h00);
        cyc(1, 1, 16'hCE03, 16'h0, 5'h00);          // simultaneous strobes
        cyc(1, 0, 16'h0000, 16'h0, 5'h00);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] r;
            r = 16'($urandom);
            if ($urandom_range(0, 3) == 0) r[7:4] = 4'($urandom_range(0, 3) * 4);
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r,
                    16'($urandom), 5'($urandom));
            end
        end

        repeat (3) @(negedge clk);
        if (scb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", scb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
